if_pc_fetch: RTL

// - PC/fetch front end: the consumer of the pipeline controller's stall vector, flush and new_pc.
// - Generates sequential 8-byte dual-issue fetch addresses and issues them to the icache over a valid/ready handshake.
// - Pairs each icache response with its PC and presents {pc, 64-bit bundle} to the IF/ID stage.
// - Applies exception redirects (flush/new_pc) and branch redirects, discarding stale in-flight responses.

---
 rtl/if_pc_fetch.sv | 136 +++++++++++++
 1 files changed

// File: rtl/if_pc_fetch.sv
// PC/fetch front end: issues 8-byte aligned fetch requests to the icache, pairs
// each response with its PC and buffers {pc, bundle} for IF/ID; handles redirects.
module if_pc_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h1c000000,
  parameter int          MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        req_valid,
  output logic [31:0] req_addr,
  input  logic        req_ready,
  input  logic        resp_valid,
  input  logic [63:0] resp_data,
  output logic        inst_valid_o,
  output logic [31:0] inst_pc_o,
  output logic [63:0] inst_o
);

  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam int AW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t        state, state_next;
  logic [31:0]   pc;
  logic [CW-1:0] in_flight, discard, buffered;
  logic          req_pend;

  logic [31:0]   tag_mem [MAX_OUTST];
  logic [AW-1:0] tag_wr, tag_rd;
  logic [95:0]   out_mem [MAX_OUTST];
  logic [AW-1:0] out_wr, out_rd;
  logic [95:0]   last_q;

  logic          redirect, hs, resp_ok, resp_drop, push, pop;
  logic [CW:0]   occupancy;
  logic [CW-1:0] in_flight_next;
  logic [31:0]   redirect_pc;
  logic          unused;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(MAX_OUTST - 1)) ? '0 : p + AW'(1);
  endfunction

  assign unused = ^{stall[6:2], new_pc[2:0], branch_target[2:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  // A request already presented stays up until accepted; only a redirect can drop it.
  always_comb begin
    req_valid = 1'b0;
    if (state == RUN && !flush && !branch_flag)
      req_valid = req_pend || (!stall[0] && occupancy < (CW+1)'(MAX_OUTST));
  end

  assign req_addr       = pc;
  assign occupancy      = {1'b0, in_flight} + {1'b0, buffered};
  assign redirect       = flush | branch_flag;
  assign hs             = req_valid & req_ready;
  assign resp_ok        = resp_valid & (in_flight != '0);
  assign resp_drop      = resp_ok & (discard != '0);
  assign push           = resp_ok & ~resp_drop & ~redirect;
  assign pop            = (buffered != '0) & ~stall[1] & ~redirect;
  assign in_flight_next = in_flight + CW'(hs) - CW'(resp_ok);
  assign redirect_pc    = flush ? {new_pc[31:3], 3'b000} : {branch_target[31:3], 3'b000};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      in_flight <= '0;
      discard   <= '0;
      buffered  <= '0;
      req_pend  <= 1'b0;
      tag_wr    <= '0;
      tag_rd    <= '0;
      out_wr    <= '0;
      out_rd    <= '0;
      last_q    <= '0;
    end else begin
      in_flight <= in_flight_next;
      if (buffered != '0) last_q <= out_mem[out_rd];
      if (redirect) begin
        // everything still in flight after this edge belongs to the old path
        pc       <= redirect_pc;
        discard  <= in_flight_next;
        buffered <= '0;
        req_pend <= 1'b0;
        tag_wr   <= '0;
        tag_rd   <= '0;
        out_wr   <= '0;
        out_rd   <= '0;
      end else begin
        if (hs) pc <= {pc[31:3] + 29'd1, 3'b000};
        req_pend <= req_valid & ~req_ready;
        if (resp_drop) discard <= discard - CW'(1);
        buffered <= buffered + CW'(push) - CW'(pop);
        if (hs)   tag_wr <= ptr_inc(tag_wr);
        if (push) tag_rd <= ptr_inc(tag_rd);
        if (push) out_wr <= ptr_inc(out_wr);
        if (pop)  out_rd <= ptr_inc(out_rd);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (hs) tag_mem[tag_wr] <= pc;
  end

  always_ff @(posedge clk) begin
    if (push) out_mem[out_wr] <= {tag_mem[tag_rd], resp_data};
  end

  assign inst_valid_o         = (buffered != '0);
  assign {inst_pc_o, inst_o}  = inst_valid_o ? out_mem[out_rd] : last_q;

  a_counters: assert property (@(posedge clk) disable iff (!rst_n)
    (occupancy <= (CW+1)'(MAX_OUTST)) && (discard <= in_flight));

endmodule
